// File: rtl/hazard_if.sv
// Hazard-control bundle: pipeline hazard sources in, stall/flush/PC control out.
// The slave modport is the controller side, the master modport is the pipeline side.
interface hazard_if #(
  parameter int XLEN = 64
);
  logic            imem_wait;
  logic            dmem_wait;
  logic            div_start;
  logic            e_is_load;
  logic [4:0]      e_rd;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic            d_use_rs1;
  logic            d_use_rs2;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            pc_en;
  logic            pc_redirect;
  logic [XLEN-1:0] pc_target;
  logic            en_fd;
  logic            en_de;
  logic            en_em;
  logic            en_mw;
  logic            flush_fd;
  logic            flush_de;
  logic            flush_em;
  logic            flush_mw;
  logic            div_busy;

  modport slave (
    input  imem_wait, dmem_wait, div_start, e_is_load, e_rd, d_rs1, d_rs2,
           d_use_rs1, d_use_rs2, redirect_valid, redirect_pc,
    output pc_en, pc_redirect, pc_target, en_fd, en_de, en_em, en_mw,
           flush_fd, flush_de, flush_em, flush_mw, div_busy
  );

  modport master (
    output imem_wait, dmem_wait, div_start, e_is_load, e_rd, d_rs1, d_rs2,
           d_use_rs1, d_use_rs2, redirect_valid, redirect_pc,
    input  pc_en, pc_redirect, pc_target, en_fd, en_de, en_em, en_mw,
           flush_fd, flush_de, flush_em, flush_mw, div_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the F/D/E/M/W pipeline: memory waits,
// multi-cycle divide, load-use interlock and E-stage redirects (with pending latch).
module hazard_ctrl #(
  parameter int XLEN    = 64,
  parameter int DIV_LAT = 8
) (
  input  logic     clk,
  input  logic     resetn,
  hazard_if.slave  hif
);

  localparam int CNT_W = $clog2(DIV_LAT);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              pend;
  logic [XLEN-1:0]   pend_pc;

  logic              load_use;
  logic              div_stall;

  assign load_use = hif.e_is_load && (hif.e_rd != 5'd0) &&
                    ((hif.d_use_rs1 && (hif.d_rs1 == hif.e_rd)) ||
                     (hif.d_use_rs2 && (hif.d_rs2 == hif.e_rd)));

  assign div_stall = ((state == IDLE) && hif.div_start) || (state == DIV);

  // Everything freezes under a data-memory wait; redirects are ignored while the
  // divider stalls because E re-presents them once it moves again.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else if (!hif.dmem_wait) begin
      case (state)
        IDLE: begin
          if (hif.div_start) begin
            state <= DIV;
            cnt   <= CNT_W'(DIV_LAT - 1);
          end
        end
        DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!div_stall) begin
        if (hif.redirect_valid) begin
          pend <= hif.imem_wait;
          if (hif.imem_wait) pend_pc <= hif.redirect_pc;
        end else if (pend && !hif.imem_wait) begin
          pend <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    hif.pc_en       = 1'b1;
    hif.pc_redirect = 1'b0;
    hif.pc_target   = '0;
    hif.en_fd       = 1'b1;
    hif.en_de       = 1'b1;
    hif.en_em       = 1'b1;
    hif.en_mw       = 1'b1;
    hif.flush_fd    = 1'b0;
    hif.flush_de    = 1'b0;
    hif.flush_em    = 1'b0;
    hif.flush_mw    = 1'b0;
    hif.div_busy    = resetn && div_stall;

    if (!resetn) begin
      hif.pc_en    = 1'b0;
      hif.en_fd    = 1'b0;
      hif.en_de    = 1'b0;
      hif.en_em    = 1'b0;
      hif.en_mw    = 1'b0;
      hif.flush_fd = 1'b1;
      hif.flush_de = 1'b1;
      hif.flush_em = 1'b1;
      hif.flush_mw = 1'b1;
    end else if (hif.dmem_wait) begin
      hif.pc_en    = 1'b0;
      hif.en_fd    = 1'b0;
      hif.en_de    = 1'b0;
      hif.en_em    = 1'b0;
      hif.flush_mw = 1'b1;
    end else if (div_stall) begin
      // The divide sits in E; bubbles drain into M while W keeps retiring.
      hif.pc_en    = 1'b0;
      hif.en_fd    = 1'b0;
      hif.en_de    = 1'b0;
      hif.flush_em = 1'b1;
    end else if (hif.redirect_valid && !hif.imem_wait) begin
      hif.pc_redirect = 1'b1;
      hif.pc_target   = hif.redirect_pc;
      hif.flush_fd    = 1'b1;
      hif.flush_de    = 1'b1;
    end else if (hif.redirect_valid) begin
      hif.pc_en    = 1'b0;
      hif.flush_fd = 1'b1;
      hif.flush_de = 1'b1;
    end else if (pend && !hif.imem_wait) begin
      hif.pc_redirect = 1'b1;
      hif.pc_target   = pend_pc;
      hif.flush_fd    = 1'b1;
    end else if (pend) begin
      hif.pc_en    = 1'b0;
      hif.flush_fd = 1'b1;
    end else if (load_use) begin
      // D is held, so F/D must keep its instruction even under a fetch wait.
      hif.pc_en    = 1'b0;
      hif.en_fd    = 1'b0;
      hif.flush_de = 1'b1;
    end else if (hif.imem_wait) begin
      hif.pc_en    = 1'b0;
      hif.flush_fd = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, divide stall and freeze, redirect
// latching/overwrite and reset behaviour, checked with immediate assertions.
module tb_hazard_ctrl;

  localparam int XLEN = 64;

  // Packed as {pc_en, pc_redirect, en_fd, en_de, en_em, en_mw,
  //            flush_fd, flush_de, flush_em, flush_mw, div_busy}
  localparam logic [10:0] DEF   = 11'b1_0_1111_0000_0;
  localparam logic [10:0] RST   = 11'b0_0_0000_1111_0;
  localparam logic [10:0] LU    = 11'b0_0_0111_0100_0;
  localparam logic [10:0] DIVS  = 11'b0_0_0011_0010_1;
  localparam logic [10:0] DMEM0 = 11'b0_0_0001_0001_0;
  localparam logic [10:0] DMEM1 = 11'b0_0_0001_0001_1;
  localparam logic [10:0] REDIR = 11'b1_1_1111_1100_0;
  localparam logic [10:0] RWAIT = 11'b0_0_1111_1100_0;
  localparam logic [10:0] PREL  = 11'b1_1_1111_1000_0;
  localparam logic [10:0] IW    = 11'b0_0_1111_1000_0;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt;

  always #5 clk = ~clk;

  hazard_if #(.XLEN(XLEN)) hif ();

  hazard_ctrl #(.XLEN(XLEN), .DIV_LAT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hif    (hif.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.imem_wait      = 1'b0;
    hif.dmem_wait      = 1'b0;
    hif.div_start      = 1'b0;
    hif.e_is_load      = 1'b0;
    hif.e_rd           = 5'd0;
    hif.d_rs1          = 5'd0;
    hif.d_rs2          = 5'd0;
    hif.d_use_rs1      = 1'b0;
    hif.d_use_rs2      = 1'b0;
    hif.redirect_valid = 1'b0;
    hif.redirect_pc    = '0;
  endtask

  task automatic check(input string tag, input logic [10:0] exp, input logic [XLEN-1:0] tgt);
    logic [10:0] obs;
    #1;
    obs = {hif.pc_en, hif.pc_redirect, hif.en_fd, hif.en_de, hif.en_em, hif.en_mw,
           hif.flush_fd, hif.flush_de, hif.flush_em, hif.flush_mw, hif.div_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ctrl: observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (hif.pc_target === tgt) else begin
      errors++;
      $error("FAIL %s pc_target: observed=%h expected=%h", tag, hif.pc_target, tgt);
    end
  endtask

  initial begin
    clr();
    resetn = 1'b0;

    // Reset: outputs forced regardless of inputs
    tick();
    check("reset_idle", RST, '0);
    hif.redirect_valid = 1'b1;
    hif.redirect_pc    = 64'h1234;
    hif.div_start      = 1'b1;
    check("reset_inputs", RST, '0);
    tick();
    clr();
    resetn = 1'b1;
    check("post_reset_default", DEF, '0);
    tick();

    // Load-use interlock
    hif.e_is_load = 1'b1; hif.e_rd = 5'd5; hif.d_rs1 = 5'd5; hif.d_use_rs1 = 1'b1;
    check("load_use_rs1", LU, '0);
    hif.d_use_rs1 = 1'b0;
    check("load_use_rs1_unused", DEF, '0);
    hif.e_rd = 5'd0; hif.d_rs1 = 5'd0; hif.d_use_rs1 = 1'b1;
    check("load_use_x0", DEF, '0);
    hif.e_rd = 5'd7; hif.d_rs1 = 5'd3; hif.d_rs2 = 5'd7; hif.d_use_rs2 = 1'b1;
    check("load_use_rs2", LU, '0);
    hif.imem_wait = 1'b1;
    check("load_use_imem_wait", LU, '0);
    hif.e_is_load = 1'b0;
    check("imem_wait_only", IW, '0);
    tick();
    clr();

    // Divide: 8 stall cycles, a redirect mid-divide must be ignored
    hif.div_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hif.redirect_valid = (i == 3);
      hif.redirect_pc    = 64'h123;
      check($sformatf("div_stall_%0d", i), DIVS, '0);
      tick();
    end
    hif.redirect_valid = 1'b0;
    check("div_done", DEF, '0);
    tick();
    hif.div_start = 1'b0;
    check("div_back_idle", DEF, '0);
    tick();

    // dmem_wait with a redirect while idle: redirect ignored, nothing latched
    hif.dmem_wait = 1'b1; hif.redirect_valid = 1'b1; hif.redirect_pc = 64'h456;
    check("dmem_ignores_redirect", DMEM0, '0);
    tick();
    clr();
    check("dmem_no_pend", DEF, '0);
    tick();

    // Divide frozen by dmem_wait at cnt=4: total busy 8+3
    busy_cnt = 0;
    hif.div_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("divf_pre_%0d", i), DIVS, '0);
      busy_cnt += int'(hif.div_busy);
      tick();
    end
    hif.dmem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("divf_frozen_%0d", i), DMEM1, '0);
      busy_cnt += int'(hif.div_busy);
      tick();
    end
    hif.dmem_wait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("divf_post_%0d", i), DIVS, '0);
      busy_cnt += int'(hif.div_busy);
      tick();
    end
    check("divf_done", DEF, '0);
    checks++;
    assert (busy_cnt == 11) else begin
      errors++;
      $error("FAIL divf_busy_total: observed=%0d expected=11", busy_cnt);
    end
    tick();
    clr();
    tick();

    // Redirect during fetch wait, released later from the pending latch
    hif.redirect_valid = 1'b1; hif.redirect_pc = 64'h8000_1000; hif.imem_wait = 1'b1;
    check("redir_wait", RWAIT, '0);
    tick();
    hif.redirect_valid = 1'b0; hif.redirect_pc = '0;
    check("pend_wait", IW, '0);
    tick();
    hif.imem_wait = 1'b0;
    check("pend_release", PREL, 64'h8000_1000);
    tick();
    check("pend_cleared", DEF, '0);
    tick();

    // Immediate redirect
    hif.redirect_valid = 1'b1; hif.redirect_pc = 64'hdead_beef_0000_0040;
    check("redir_now", REDIR, 64'hdead_beef_0000_0040);
    tick();
    clr();
    check("redir_now_no_pend", DEF, '0);
    tick();

    // Overwrite of an older pending redirect
    hif.redirect_valid = 1'b1; hif.redirect_pc = 64'h100; hif.imem_wait = 1'b1;
    check("ovw_first", RWAIT, '0);
    tick();
    hif.redirect_pc = 64'h200;
    check("ovw_second", RWAIT, '0);
    tick();
    clr();
    check("ovw_release", PREL, 64'h200);
    tick();
    check("ovw_cleared", DEF, '0);
    tick();

    // Reset mid-divide with a redirect pending
    hif.redirect_valid = 1'b1; hif.redirect_pc = 64'h300; hif.imem_wait = 1'b1;
    check("rst_mid_pend", RWAIT, '0);
    tick();
    clr();
    hif.div_start = 1'b1;
    check("rst_mid_div0", DIVS, '0);
    tick();
    check("rst_mid_div1", DIVS, '0);
    tick();
    resetn = 1'b0;
    check("rst_mid_assert", RST, '0);
    tick();
    check("rst_mid_hold", RST, '0);
    tick();
    resetn = 1'b1;
    hif.div_start = 1'b0;
    check("rst_mid_release", DEF, '0);
    tick();
    check("rst_mid_after", DEF, '0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
